// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer: fetches 8-bit instructions, drives a 2-bit-op ALU, writes results to a 4x8 register file.
// Optional feature macro ALU_ZERO_FLAG_EN adds zero_flag output and halt_on_zero input.
module alu_seq_ctrl #(
  parameter int PROG_LEN = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  output logic [1:0]        alu_op,
  output logic [7:0]        alu_in1,
  output logic [7:0]        alu_in2,
  input  logic [7:0]        alu_out,
  input  logic              alu_write_reg,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
`ifdef ALU_ZERO_FLAG_EN
  output logic              zero_flag,
  input  logic              halt_on_zero,
`endif
  output logic [7:0]        dbg_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [7:0]        regs [4];
  logic              halt_now;

  assign dbg_rdata = regs[cfg_addr];

`ifdef ALU_ZERO_FLAG_EN
  assign halt_now = halt_on_zero && alu_write_reg && (alu_out == 8'd0);
`else
  assign halt_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      imem_addr <= '0;
      ir        <= '0;
      alu_op    <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
`ifdef ALU_ZERO_FLAG_EN
      zero_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A cfg write coinciding with start lands before the first EXEC reads the file
          if (cfg_we) regs[cfg_addr] <= cfg_wdata;
          if (start) begin
            state     <= FETCH;
            pc        <= '0;
            imem_addr <= '0;
            busy      <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
            zero_flag <= 1'b0;
`endif
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          ir    <= imem_data;
          state <= EXEC;
        end
        EXEC: begin
          alu_op  <= ir[7:6];
          alu_in1 <= regs[ir[3:2]];
          alu_in2 <= regs[ir[1:0]];
          state   <= WB;
        end
        WB: begin
          if (alu_write_reg) regs[ir[5:4]] <= alu_out;
`ifdef ALU_ZERO_FLAG_EN
          zero_flag <= alu_write_reg && (alu_out == 8'd0);
`endif
          // pc stops at the last instruction so a full-range program never wraps
          if (pc == LAST_PC || halt_now) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            pc        <= pc + 1'b1;
            imem_addr <= pc + 1'b1;
            state     <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
